// File: rtl/exc_sequencer_if.sv
// Exception sequencer bus interface.
// Groups the commit-stage inputs (wb_*), the interrupt indication, the CP0 inputs, the CP0
// commit port, the pipeline flush/busy outputs and the fetch-redirect handshake.
// Modports:
//   master - environment side: drives wb_*, int_sig, cp0_*, redir_ready; observes the rest.
//   slave  - sequencer side: the inverse of master.
interface exc_sequencer_if;
  // Commit stage
  logic        wb_valid;
  logic        wb_exc;
  logic        wb_eret;
  logic        wb_bd;
  logic [4:0]  wb_exccode;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  // CP0 inputs
  logic        int_sig;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  // CP0 commit port
  logic        commit_exc;
  logic        commit_eret;
  logic        commit_bd;
  logic [4:0]  commit_code;
  logic [31:0] commit_epc;
  logic [31:0] commit_bvaddr;
  // Pipeline control
  logic        flush;
  logic        busy;
  // Fetch redirect
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;

  modport master (
    output wb_valid, wb_exc, wb_eret, wb_bd, wb_exccode, wb_pc, wb_badvaddr,
    output int_sig, cp0_status, cp0_epc, redir_ready,
    input  commit_exc, commit_eret, commit_bd, commit_code, commit_epc, commit_bvaddr,
    input  flush, busy, redir_valid, redir_pc
  );

  modport slave (
    input  wb_valid, wb_exc, wb_eret, wb_bd, wb_exccode, wb_pc, wb_badvaddr,
    input  int_sig, cp0_status, cp0_epc, redir_ready,
    output commit_exc, commit_eret, commit_bd, commit_code, commit_epc, commit_bvaddr,
    output flush, busy, redir_valid, redir_pc
  );
endinterface

// File: rtl/exc_sequencer.sv
// Exception / ERET sequencer.
// Captures an exception, interrupt or ERET at the commit stage, pulses the CP0 commit port for
// one cycle, holds the pipeline flush for FLUSH_CYCLES further cycles, then presents a fetch
// redirect until it is accepted.
// Parameters:
//   FLUSH_CYCLES - extra flush cycles after the commit cycle (0..15).
// Ports:
//   clk    - clock, all state on rising edge.
//   resetn - asynchronous active-low reset.
//   bus_io - exc_sequencer_if.slave: wb_*/int_sig/cp0_* in, commit_*/flush/busy/redir_* out,
//            redir_ready in.
// Build option:
//   EXC_SEQ_IRQ_EN - when defined, int_sig raises an interrupt (highest priority, code 0);
//                    when undefined, int_sig is ignored.
module exc_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic            clk,
  input logic            resetn,
  exc_sequencer_if.slave bus_io
);

`ifdef EXC_SEQ_IRQ_EN
  localparam logic IrqEn = 1'b1;
`else
  localparam logic IrqEn = 1'b0;
`endif

  localparam logic [31:0] VecBev1   = 32'hBFC0_0380;
  localparam logic [31:0] VecBev0   = 32'h8000_0180;
  localparam int unsigned StatusBev = 22;
  // Counter value on the last drain cycle; unused when FLUSH_CYCLES is 0.
  localparam logic [3:0]  DrainLast = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCommit,
    StDrain,
    StRedirect
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic        eret_q, eret_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bvaddr_q, bvaddr_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        irq;
  logic        evt;
  logic        capture;
  logic        commit_exc;
  logic        commit_eret;
  logic        flush;
  logic        redir_valid;

  assign irq = bus_io.int_sig & IrqEn;
  assign evt = bus_io.wb_valid & (irq | bus_io.wb_exc | bus_io.wb_eret);

  // Cause decode; only latched on the capture cycle.
  // Priority irq > exception > ERET; losing causes are dropped.
  always_comb begin
    code_d   = irq ? 5'd0 : bus_io.wb_exccode;
    eret_d   = ~irq & ~bus_io.wb_exc & bus_io.wb_eret;
    bd_d     = bus_io.wb_bd;
    // Delay-slot instructions report the branch PC; wraps modulo 2^32.
    epc_d    = bus_io.wb_bd ? (bus_io.wb_pc - 32'd4) : bus_io.wb_pc;
    bvaddr_d = bus_io.wb_badvaddr;
    if (eret_d) begin
      redir_pc_d = bus_io.cp0_epc;
    end else if (bus_io.cp0_status[StatusBev]) begin
      redir_pc_d = VecBev1;
    end else begin
      redir_pc_d = VecBev0;
    end
  end

  // Next state and decoded outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    commit_exc  = 1'b0;
    commit_eret = 1'b0;
    flush       = 1'b0;
    redir_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (evt) begin
          capture = 1'b1;
          state_d = StCommit;
        end
      end
      StCommit: begin
        commit_exc  = 1'b1;
        commit_eret = eret_q;
        flush       = 1'b1;
        cnt_d       = 4'd0;
        state_d     = (FLUSH_CYCLES == 0) ? StRedirect : StDrain;
      end
      StDrain: begin
        flush = 1'b1;
        if (cnt_q == DrainLast) begin
          cnt_d   = 4'd0;
          state_d = StRedirect;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRedirect: begin
        redir_valid = 1'b1;
        if (bus_io.redir_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured fields hold until the next capture; cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      code_q     <= 5'd0;
      bd_q       <= 1'b0;
      eret_q     <= 1'b0;
      epc_q      <= 32'd0;
      bvaddr_q   <= 32'd0;
      redir_pc_q <= 32'd0;
    end else if (capture) begin
      code_q     <= code_d;
      bd_q       <= bd_d;
      eret_q     <= eret_d;
      epc_q      <= epc_d;
      bvaddr_q   <= bvaddr_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign bus_io.commit_exc    = commit_exc;
  assign bus_io.commit_eret   = commit_eret;
  assign bus_io.commit_bd     = bd_q;
  assign bus_io.commit_code   = code_q;
  assign bus_io.commit_epc    = epc_q;
  assign bus_io.commit_bvaddr = bvaddr_q;
  assign bus_io.flush         = flush;
  assign bus_io.busy          = (state_q != StIdle);
  assign bus_io.redir_valid   = redir_valid;
  assign bus_io.redir_pc      = redir_pc_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Testbench for exc_sequencer.
// Two instances (FLUSH_CYCLES = 2 and 0) see identical stimulus. A timeline model (cycles since
// capture) predicts every output each cycle; directed cases add literal expectations.
module tb_exc_sequencer;

  localparam int unsigned F0 = 2;
  localparam int unsigned F1 = 0;
`ifdef EXC_SEQ_IRQ_EN
  localparam bit IrqOn = 1'b1;
`else
  localparam bit IrqOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_exc = 1'b0;
  logic        wb_eret = 1'b0;
  logic        wb_bd = 1'b0;
  logic        int_sig = 1'b0;
  logic        redir_ready = 1'b0;
  logic [4:0]  wb_exccode = 5'd0;
  logic [31:0] wb_pc = 32'd0;
  logic [31:0] wb_badvaddr = 32'd0;
  logic [31:0] cp0_status = 32'd0;
  logic [31:0] cp0_epc = 32'd0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic        exc;
    logic        eret;
    logic        bd;
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] bva;
    logic        flush;
    logic        busy;
    logic        rv;
    logic [31:0] rpc;
  } out_t;

  typedef struct packed {
    logic [4:0]  code;
    logic        bd;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] bva;
    logic [31:0] rpc;
  } rec_t;

  out_t obs [2];

  exc_sequencer_if bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus[g].wb_valid    = wb_valid;
    assign bus[g].wb_exc      = wb_exc;
    assign bus[g].wb_eret     = wb_eret;
    assign bus[g].wb_bd       = wb_bd;
    assign bus[g].wb_exccode  = wb_exccode;
    assign bus[g].wb_pc       = wb_pc;
    assign bus[g].wb_badvaddr = wb_badvaddr;
    assign bus[g].int_sig     = int_sig;
    assign bus[g].cp0_status  = cp0_status;
    assign bus[g].cp0_epc     = cp0_epc;
    assign bus[g].redir_ready = redir_ready;

    exc_sequencer #(
      .FLUSH_CYCLES((g == 0) ? F0 : F1)
    ) u_dut (
      .clk   (clk),
      .resetn(resetn),
      .bus_io(bus[g])
    );

    assign obs[g] = '{exc: bus[g].commit_exc, eret: bus[g].commit_eret, bd: bus[g].commit_bd,
                      code: bus[g].commit_code, epc: bus[g].commit_epc,
                      bva: bus[g].commit_bvaddr, flush: bus[g].flush, busy: bus[g].busy,
                      rv: bus[g].redir_valid, rpc: bus[g].redir_pc};
  end

  // ---------------- model ----------------
  bit          m_active [2];
  int unsigned m_n      [2];   // cycles since capture, 1 = commit cycle
  rec_t        m_rec    [2];

  function automatic int unsigned flush_len(input int i);
    return (i == 0) ? F0 : F1;
  endfunction

  function automatic bit is_event();
    return wb_valid && ((IrqOn && int_sig) || wb_exc || wb_eret);
  endfunction

  function automatic rec_t decode();
    rec_t r;
    bit   irq;
    irq    = IrqOn && int_sig;
    r.code = irq ? 5'd0 : wb_exccode;
    r.eret = !irq && !wb_exc && wb_eret;
    r.bd   = wb_bd;
    r.epc  = wb_bd ? wb_pc - 32'd4 : wb_pc;
    r.bva  = wb_badvaddr;
    r.rpc  = r.eret ? cp0_epc : (cp0_status[22] ? 32'hBFC0_0380 : 32'h8000_0180);
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] <= 1'b0;
        m_n[i]      <= 0;
        m_rec[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_active[i]) begin
          if (is_event()) begin
            m_active[i] <= 1'b1;
            m_n[i]      <= 1;
            m_rec[i]    <= decode();
          end
        end else if (m_n[i] >= flush_len(i) + 2 && redir_ready) begin
          m_active[i] <= 1'b0;
        end else begin
          m_n[i] <= m_n[i] + 1;
        end
      end
    end
  end

  function automatic out_t expect_out(input int i);
    out_t e;
    bit   act;
    act     = m_active[i];
    e.exc   = act && (m_n[i] == 1);
    e.eret  = e.exc && m_rec[i].eret;
    e.bd    = m_rec[i].bd;
    e.code  = m_rec[i].code;
    e.epc   = m_rec[i].epc;
    e.bva   = m_rec[i].bva;
    e.flush = act && (m_n[i] <= flush_len(i) + 1);
    e.busy  = act;
    e.rv    = act && (m_n[i] >= flush_len(i) + 2);
    e.rpc   = m_rec[i].rpc;
    return e;
  endfunction

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_exc [2], n_eret [2], n_flush [2], n_rv [2], n_hs [2], n_busy [2];
  int b_exc [2], b_eret [2], b_flush [2], b_rv [2], b_hs [2], b_busy [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic snap();
    b_exc = n_exc; b_eret = n_eret; b_flush = n_flush;
    b_rv = n_rv; b_hs = n_hs; b_busy = n_busy;
  endtask

  task automatic clear_inputs();
    wb_valid = 0; wb_exc = 0; wb_eret = 0; wb_bd = 0; int_sig = 0;
    wb_exccode = 0; wb_pc = 0; wb_badvaddr = 0; cp0_status = 0; cp0_epc = 0;
  endtask

  // One event in the capture cycle, then optionally garbage while busy, then wait for idle.
  task automatic run_case(input logic v, input logic exc, input logic eret, input logic bd,
                          input logic irq, input logic [4:0] code, input logic [31:0] pc,
                          input logic [31:0] bva, input logic [31:0] status,
                          input logic [31:0] epc, input int delay, input bit noisy);
    @(posedge clk); #1;
    wb_valid = v; wb_exc = exc; wb_eret = eret; wb_bd = bd; int_sig = irq;
    wb_exccode = code; wb_pc = pc; wb_badvaddr = bva; cp0_status = status; cp0_epc = epc;
    redir_ready = 1'b0;
    snap();
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      redir_ready = (k > delay);
      if (noisy && k <= 2) begin
        wb_valid = 1; wb_exc = 1; wb_eret = 1; int_sig = 1; wb_bd = ~bd;
        wb_exccode = 5'h1f; wb_pc = 32'hDEAD_BEEF; wb_badvaddr = 32'hCAFE_0000;
        cp0_status = ~status; cp0_epc = 32'h1234_5678;
      end else begin
        clear_inputs();
      end
      if (k >= 3 && !m_active[0] && !m_active[1]) break;
    end
    check("settle_idle", 32'(bus[0].busy | bus[1].busy), 32'd0);
    redir_ready = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_code;
    int         exp_busy;

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          out_t e;
          e = expect_out(i);
          n_checks++;
          if (obs[i] !== e) begin
            n_errors++;
            $display("FAIL cycle_outputs dut%0d t=%0t: got %h expected %h", i, $time, obs[i], e);
          end
          if (resetn) begin
            if (obs[i].exc) n_exc[i]++;
            if (obs[i].eret) n_eret[i]++;
            if (obs[i].flush) n_flush[i]++;
            if (obs[i].rv) n_rv[i]++;
            if (obs[i].rv && redir_ready) n_hs[i]++;
            if (obs[i].busy) n_busy[i]++;
          end
        end
      end
    join_none

    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check("reset_busy", 32'(bus[0].busy), 32'd0);
    check("reset_flush", 32'(bus[0].flush), 32'd0);
    check("reset_redir_pc", bus[1].redir_pc, 32'd0);
    check("reset_epc", bus[0].commit_epc, 32'd0);

    // Exception, BEV=1, immediate ready.
    run_case(1, 1, 0, 0, 0, 5'h04, 32'h8000_1000, 32'h0000_0044, 32'h0040_0000, 0, 0, 1);
    check("c1_exc_pulses", 32'(n_exc[0] - b_exc[0]), 32'd1);
    check("c1_flush_cycles", 32'(n_flush[0] - b_flush[0]), 32'd3);
    check("c1_busy_cycles", 32'(n_busy[0] - b_busy[0]), 32'd4);
    check("c1_flush_f0", 32'(n_flush[1] - b_flush[1]), 32'd1);
    check("c1_code", 32'(bus[0].commit_code), 32'd4);
    check("c1_epc", bus[0].commit_epc, 32'h8000_1000);
    check("c1_bvaddr", bus[0].commit_bvaddr, 32'h0000_0044);
    check("c1_redir_pc", bus[0].redir_pc, 32'hBFC0_0380);

    // ERET with late ready.
    run_case(1, 0, 1, 0, 0, 5'h00, 32'h8000_0400, 0, 32'h0040_0000, 32'h8000_2000, 3, 1);
    check("c2_eret_pulses", 32'(n_eret[1] - b_eret[1]), 32'd1);
    check("c2_exc_pulses", 32'(n_exc[1] - b_exc[1]), 32'd1);
    check("c2_redir_cycles", 32'(n_rv[1] - b_rv[1]), 32'd3);
    check("c2_handshakes", 32'(n_hs[1] - b_hs[1]), 32'd1);
    check("c2_redir_pc", bus[1].redir_pc, 32'h8000_2000);

    // Exception + ERET + interrupt together, delay slot, BEV=0.
    run_case(1, 1, 1, 1, 1, 5'h0d, 32'h8000_0010, 0, 32'h0000_0000, 32'h8000_2000, 0, 1);
    exp_code = IrqOn ? 5'h00 : 5'h0d;
    check("c3_code", 32'(bus[0].commit_code), 32'(exp_code));
    check("c3_bd", 32'(bus[0].commit_bd), 32'd1);
    check("c3_epc", bus[0].commit_epc, 32'h8000_000C);
    check("c3_no_eret", 32'(n_eret[0] - b_eret[0]), 32'd0);
    check("c3_redir_pc", bus[0].redir_pc, 32'h8000_0180);

    // Delay slot at PC 0 wraps.
    run_case(1, 1, 0, 1, 0, 5'h0a, 32'h0000_0000, 0, 32'h0040_0000, 0, 0, 1);
    check("c4_epc_wrap", bus[1].commit_epc, 32'hFFFF_FFFC);

    // Interrupt alone.
    run_case(1, 0, 0, 0, 1, 5'h00, 32'h8000_0020, 0, 32'h0040_0000, 0, 0, 0);
    exp_busy = IrqOn ? 4 : 0;
    check("c5_irq_busy", 32'(n_busy[0] - b_busy[0]), 32'(exp_busy));

    // Exception flag without wb_valid.
    run_case(0, 1, 1, 0, 1, 5'h04, 32'h8000_0030, 0, 0, 0, 0, 0);
    check("c6_no_event", 32'(n_busy[0] - b_busy[0] + n_busy[1] - b_busy[1]), 32'd0);

    // Reset asserted during drain.
    @(posedge clk); #1;
    wb_valid = 1; wb_exc = 1; wb_exccode = 5'h0c; wb_pc = 32'h8000_3000;
    redir_ready = 1'b0;
    snap();
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    #2 resetn = 1'b0;
    #1;
    check("c7_flush_in_reset", 32'(bus[0].flush), 32'd0);
    check("c7_busy_in_reset", 32'(bus[0].busy | bus[1].busy), 32'd0);
    check("c7_code_in_reset", 32'(bus[0].commit_code), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    check("c7_no_redirect", 32'(n_rv[0] - b_rv[0]), 32'd0);
    check("c7_one_commit", 32'(n_exc[0] - b_exc[0]), 32'd1);
    run_case(1, 1, 0, 0, 0, 5'h04, 32'h8000_1000, 0, 32'h0040_0000, 0, 0, 1);
    check("c7_after_flush", 32'(n_flush[0] - b_flush[0]), 32'd3);
    check("c7_after_hs", 32'(n_hs[0] - b_hs[0]), 32'd1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
